// File: rtl/pio_read_poller.sv
// Avalon-MM read initiator that polls one PIO register on a fixed period and
// debounces the sampled value before publishing it with a one-cycle change strobe.
module pio_read_poller #(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned POLL_DIV     = 50000,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STABLE_CNT   = 3,
  parameter logic [1:0]  POLL_ADDR    = 2'd0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic              changed
);

  localparam int unsigned PresW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned LatW  = $clog2(READ_LATENCY + 1);
  localparam int unsigned StbW  = $clog2(STABLE_CNT + 1);

  localparam logic [PresW-1:0] PresMax = PresW'(POLL_DIV - 1);
  localparam logic [LatW-1:0]  LatInit = LatW'(READ_LATENCY);
  localparam logic [StbW-1:0]  StbMax  = StbW'(STABLE_CNT);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StCapt
  } state_e;

  state_e            state_q, state_d;
  logic [PresW-1:0]  presc_q, presc_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] cand_q, cand_d;
  logic [StbW-1:0]   stb_q, stb_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              valid_q, valid_d;
  logic              changed_q, changed_d;
  logic              tick;

  if (DATA_W < 32) begin : gen_unused
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:DATA_W];
  end

  // Prescaler: free-runs while enabled, parked at zero otherwise.
  assign tick = enable && (presc_q == PresMax);

  always_comb begin
    presc_d = '0;
    if (enable) begin
      presc_d = (presc_q == PresMax) ? '0 : presc_q + PresW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    sample_d    = sample_q;
    cand_d      = cand_q;
    stb_d       = stb_q;
    value_d     = value_q;
    valid_d     = valid_q;
    changed_d   = 1'b0;
    avm_read    = 1'b0;
    avm_address = 2'd0;

    unique case (state_q)
      StIdle: begin
        // Ticks seen outside idle are simply lost.
        if (tick) begin
          state_d = StReq;
        end
      end
      StReq: begin
        avm_read    = 1'b1;
        avm_address = POLL_ADDR;
        if (!avm_waitrequest) begin
          state_d = StWait;
          lat_d   = LatInit;
        end
      end
      StWait: begin
        lat_d = lat_q - LatW'(1);
        if (lat_q == LatW'(1)) begin
          sample_d = avm_readdata[DATA_W-1:0];
          state_d  = StCapt;
        end
      end
      StCapt: begin
        if (sample_q == cand_q) begin
          if (stb_q != StbMax) begin
            stb_d = stb_q + StbW'(1);
          end
        end else begin
          cand_d = sample_q;
          stb_d  = StbW'(1);
        end
        // Re-accepting the value already published is not a change.
        if ((stb_d >= StbMax) && (!valid_q || (cand_d != value_q))) begin
          value_d   = cand_d;
          valid_d   = 1'b1;
          changed_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      lat_q     <= '0;
      sample_q  <= '0;
      cand_q    <= '0;
      stb_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      lat_q     <= lat_d;
      sample_q  <= sample_d;
      cand_q    <= cand_d;
      stb_q     <= stb_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign changed     = changed_q;

endmodule

// File: tb/tb_pio_read_poller.sv
// Bench for pio_read_poller: per-poll vector table, directed stall/latency/reset
// sequences and a randomized run, all checked cycle by cycle against a timeline model.
module tb_pio_read_poller;

  localparam int unsigned DataW     = 10;
  localparam int unsigned PollDiv   = 8;
  localparam int unsigned ReadLat   = 1;
  localparam int unsigned StableCnt = 3;
  localparam logic [1:0]  PollAddr  = 2'd0;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             enable = 1'b0;
  logic             avm_waitrequest = 1'b0;
  logic [1:0]       avm_address;
  logic             avm_read;
  logic [31:0]      avm_readdata;
  logic [DataW-1:0] value;
  logic             value_valid;
  logic             changed;
  logic [DataW-1:0] slave_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pio_read_poller #(
    .DATA_W      (DataW),
    .POLL_DIV    (PollDiv),
    .READ_LATENCY(ReadLat),
    .STABLE_CNT  (StableCnt),
    .POLL_ADDR   (PollAddr)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .value          (value),
    .value_valid    (value_valid),
    .changed        (changed)
  );

  // PIO slave: registers its data on an accepted read, junk on every other cycle.
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) avm_readdata <= {22'($urandom), slave_data};
    else avm_readdata <= $urandom;
  end

  // Timeline model: a poll is a request window, an accept cycle A, and a
  // decision ReadLat+1 cycles later; debounce is "last StableCnt samples equal".
  int               t;
  int               m_cnt;
  bit               m_busy;
  bit               m_req;
  int               m_capt_at;
  logic [DataW-1:0] m_sample;
  logic [DataW-1:0] hist[$];
  logic [DataW-1:0] m_value;
  bit               m_valid;
  bit               m_changed;
  int               rise_t, chg_t, n_pulses;
  logic             prev_read;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_cnt = 0;
    m_busy = 0;
    m_req = 0;
    m_capt_at = -1;
    hist.delete();
    m_value = '0;
    m_valid = 0;
    m_changed = 0;
    prev_read = 1'b0;
  endtask

  task automatic model_advance();
    bit tick, take, same;
    tick = enable && (m_cnt == PollDiv - 1);
    take = tick && !m_busy;
    m_cnt = enable ? (m_cnt + 1) % PollDiv : 0;
    m_changed = 0;
    if (m_req && !avm_waitrequest) begin
      m_req = 0;
      m_sample = slave_data;
      m_capt_at = t + ReadLat + 1;
    end
    if (t == m_capt_at) begin
      hist.push_back(m_sample);
      if (hist.size() > StableCnt) void'(hist.pop_front());
      same = (hist.size() == StableCnt);
      foreach (hist[i]) if (hist[i] != m_sample) same = 0;
      if (same && (!m_valid || m_sample != m_value)) begin
        m_value = m_sample;
        m_valid = 1;
        m_changed = 1;
      end
      m_busy = 0;
      m_capt_at = -1;
    end
    if (take) begin
      m_busy = 1;
      m_req = 1;
    end
    t++;
  endtask

  // Called at posedge+1 with inputs applied; checks this cycle, advances one clock.
  task automatic step();
    @(negedge clk);
    check("avm_read", avm_read, m_req);
    check("avm_address", avm_address, m_req ? PollAddr : 2'd0);
    check("value", value, m_value);
    check("value_valid", value_valid, m_valid);
    check("changed", changed, m_changed);
    if (avm_read && !prev_read) rise_t = t;
    if (changed) begin
      chg_t = t;
      n_pulses++;
    end
    prev_read = avm_read;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("reset_avm_read", avm_read, 1'b0);
    check("reset_avm_address", avm_address, 2'd0);
    check("reset_value", value, '0);
    check("reset_value_valid", value_valid, 1'b0);
    check("reset_changed", changed, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_read();
    for (int k = 0; k < 24 && !avm_read; k++) step();
    check("read_request_seen", avm_read, 1'b1);
  endtask

  typedef struct {
    logic [DataW-1:0] data;
    logic [DataW-1:0] exp_value;
    logic             exp_valid;
    int               exp_pulses;
  } poll_vec_t;

  poll_vec_t tbl[$];

  task automatic add_vec(input logic [DataW-1:0] d, input logic [DataW-1:0] v,
                         input logic vl, input int p);
    poll_vec_t r;
    r.data = d;
    r.exp_value = v;
    r.exp_valid = vl;
    r.exp_pulses = p;
    tbl.push_back(r);
  endtask

  initial begin
    model_reset();
    rise_t = -1;
    chg_t = -1;
    n_pulses = 0;

    // Toggling never settles; then 0AA, 155, a 3FF glitch, and finally zero.
    for (int i = 0; i < 10; i++) add_vec((i % 2 == 0) ? 10'h0AA : 10'h155, 10'h000, 1'b0, 0);
    add_vec(10'h0AA, 10'h000, 1'b0, 0);
    add_vec(10'h0AA, 10'h000, 1'b0, 0);
    add_vec(10'h0AA, 10'h0AA, 1'b1, 1);
    add_vec(10'h155, 10'h0AA, 1'b1, 0);
    add_vec(10'h155, 10'h0AA, 1'b1, 0);
    add_vec(10'h155, 10'h155, 1'b1, 1);
    add_vec(10'h3FF, 10'h155, 1'b1, 0);
    add_vec(10'h3FF, 10'h155, 1'b1, 0);
    add_vec(10'h155, 10'h155, 1'b1, 0);
    add_vec(10'h155, 10'h155, 1'b1, 0);
    add_vec(10'h155, 10'h155, 1'b1, 0);
    add_vec(10'h000, 10'h155, 1'b1, 0);
    add_vec(10'h000, 10'h155, 1'b1, 0);
    add_vec(10'h000, 10'h000, 1'b1, 1);

    #1;
    enable = 1'b1;
    do_reset();

    // Each window covers one poll: accept at offset 4, result visible at offset 7.
    slave_data = tbl[0].data;
    repeat (4) step();
    foreach (tbl[i]) begin
      slave_data = tbl[i].data;
      n_pulses = 0;
      repeat (PollDiv) step();
      check($sformatf("vec%0d_value", i), value, tbl[i].exp_value);
      check($sformatf("vec%0d_valid", i), value_valid, tbl[i].exp_valid);
      check($sformatf("vec%0d_pulses", i), n_pulses, tbl[i].exp_pulses);
    end

    // Tick-to-update latency: changed lands 3 cycles after the read request.
    do_reset();
    slave_data = 10'h2A5;
    rise_t = -1;
    chg_t = -1;
    for (int k = 0; k < 40 && !value_valid; k++) step();
    step();
    check("latency_req_to_changed", chg_t - rise_t, 3);
    check("latency_value", value, 10'h2A5);

    // Stalled requests: address/read held, ticks during a long stall dropped.
    slave_data = 10'h1C3;
    avm_waitrequest = 1'b1;
    wait_read();
    repeat (5) step();
    check("stall_read_held", avm_read, 1'b1);
    avm_waitrequest = 1'b0;
    step();
    check("stall_read_released", avm_read, 1'b0);
    avm_waitrequest = 1'b1;
    wait_read();
    repeat (12) step();
    avm_waitrequest = 1'b0;
    repeat (30) step();
    check("stall_accept_value", value, 10'h1C3);

    // Reset while a read is in its latency window.
    slave_data = 10'h2A5;
    wait_read();
    step();
    do_reset();
    for (int k = 0; k < 24 && !avm_read; k++) step();
    check("first_poll_after_reset", t, 8);
    repeat (24) step();
    check("reaccept_value", value, 10'h2A5);
    check("reaccept_valid", value_valid, 1'b1);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom % 16) != 0;
      avm_waitrequest = ($urandom % 4) == 0;
      if ($urandom % 40 == 0) begin
        case ($urandom % 4)
          0: slave_data = 10'h155;
          1: slave_data = 10'h0AA;
          2: slave_data = 10'h3FF;
          default: slave_data = DataW'($urandom);
        endcase
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
